// File: rtl/corral_turn_sequencer.sv
// Turn sequencer: captures a move, issues it to the game core, and bursts the results onto data.
// Build option CORRAL_MOVE_COUNT_EN appends a saturating move-count nibble to every burst.
module corral_turn_sequencer #(
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] move,
  input  logic       enter,
  output logic       game_enter,
  output logic [2:0] game_move,
  input  logic       game_ready,
  input  logic [3:0] game_cowboypos,
  input  logic [3:0] game_horsepos,
  input  logic       game_gameover,
  input  logic       game_lostwon,
  output logic [3:0] data,
  output logic       frame,
  output logic       gameover,
  output logic       lostwon,
  output logic       ready,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COW,
    S_HORSE,
    S_STAT,
    S_MOVES
  } state_t;

  localparam logic [7:0]  HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TMO_LD  = 16'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic        enter_q;
  logic [15:0] tmo_q;
  logic [7:0]  dwell_q;
  logic [3:0]  cow_q;
  logic [3:0]  horse_q;
  logic        go_cap_q;
  logic        lw_cap_q;
  logic [3:0]  data_q;
  logic        frame_q;
  logic        gameover_q;
  logic        lostwon_q;
  logic        ready_q;
  logic        terr_q;
  logic        genter_q;
  logic [2:0]  gmove_q;
`ifdef CORRAL_MOVE_COUNT_EN
  logic [3:0]  cnt_q;
  logic        clr_q;
`endif

  logic rise_d;
  logic dwell_done_d;

  assign rise_d       = enter & ~enter_q;
  assign dwell_done_d = (dwell_q == 8'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      enter_q    <= 1'b0;
      tmo_q      <= '0;
      dwell_q    <= '0;
      cow_q      <= '0;
      horse_q    <= '0;
      go_cap_q   <= 1'b0;
      lw_cap_q   <= 1'b0;
      data_q     <= '0;
      frame_q    <= 1'b0;
      gameover_q <= 1'b1;
      lostwon_q  <= 1'b0;
      ready_q    <= 1'b0;
      terr_q     <= 1'b0;
      genter_q   <= 1'b0;
      gmove_q    <= '0;
`ifdef CORRAL_MOVE_COUNT_EN
      cnt_q      <= '0;
      clr_q      <= 1'b0;
`endif
    end else begin
      enter_q  <= enter;
      genter_q <= 1'b0;
      gmove_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (rise_d) begin
            state_q  <= S_ISSUE;
            ready_q  <= 1'b0;
            genter_q <= 1'b1;
            gmove_q  <= move;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          tmo_q   <= TMO_LD;
`ifdef CORRAL_MOVE_COUNT_EN
          clr_q   <= 1'b0;
          if (clr_q)
            cnt_q <= 4'd1;
          else if (cnt_q != 4'hF)
            cnt_q <= cnt_q + 4'd1;
`endif
        end
        S_WAIT: begin
          // ready in the expiry cycle takes priority over the timeout
          if (game_ready) begin
            state_q  <= S_COW;
            cow_q    <= game_cowboypos;
            horse_q  <= game_horsepos;
            go_cap_q <= game_gameover;
            lw_cap_q <= game_lostwon;
            data_q   <= game_cowboypos;
            frame_q  <= 1'b1;
            dwell_q  <= HOLD_LD;
          end else if (tmo_q == 16'd1) begin
            state_q  <= S_IDLE;
            terr_q   <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            tmo_q    <= tmo_q - 16'd1;
          end
        end
        S_COW: begin
          if (dwell_done_d) begin
            state_q <= S_HORSE;
            data_q  <= horse_q;
            frame_q <= 1'b0;
            dwell_q <= HOLD_LD;
          end else begin
            dwell_q <= dwell_q - 8'd1;
          end
        end
        S_HORSE: begin
          if (dwell_done_d) begin
            state_q    <= S_STAT;
            data_q     <= {2'b00, lw_cap_q, go_cap_q};
            gameover_q <= go_cap_q;
            lostwon_q  <= lw_cap_q;
            dwell_q    <= HOLD_LD;
`ifdef CORRAL_MOVE_COUNT_EN
            if (go_cap_q)
              clr_q <= 1'b1;
`endif
          end else begin
            dwell_q <= dwell_q - 8'd1;
          end
        end
        S_STAT: begin
          if (dwell_done_d) begin
`ifdef CORRAL_MOVE_COUNT_EN
            state_q <= S_MOVES;
            data_q  <= cnt_q;
            dwell_q <= HOLD_LD;
`else
            state_q <= S_IDLE;
            data_q  <= '0;
            ready_q <= 1'b1;
`endif
          end else begin
            dwell_q <= dwell_q - 8'd1;
          end
        end
`ifdef CORRAL_MOVE_COUNT_EN
        S_MOVES: begin
          if (dwell_done_d) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ready_q <= 1'b1;
          end else begin
            dwell_q <= dwell_q - 8'd1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          data_q  <= '0;
          frame_q <= 1'b0;
        end
      endcase
    end
  end

  assign game_enter  = genter_q;
  assign game_move   = gmove_q;
  assign data        = data_q;
  assign frame       = frame_q;
  assign gameover    = gameover_q;
  assign lostwon     = lostwon_q;
  assign ready       = ready_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/corral_turn_sequencer.md
# corral_turn_sequencer

Turn sequencer for the Corral game core. Captures a player move on a rising edge of `enter`, issues it to the game core as a one-cycle command, waits with a timeout for the core's `ready`, then serialises the resulting cowboy position, horse position and status onto the 4-bit `data` pin as a framed burst. It sits between the chip pins and the `game` core, replacing ad-hoc output muxing with a single owned sequence.

## Interface
- `HOLD_CYCLES`, default 1: cycles each output nibble is held on `data`. Legal range 1..255.
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT for `game_ready`. Legal range 1..65535.
- `clock` in 1: system clock, all state updates on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `move` in 3: player move, sampled together with `enter`.
- `enter` in 1: player strobe, level input; only its rising edge is used.
- `game_enter` out 1: one-cycle move command to the core.
- `game_move` out 3: move for the core, valid while `game_enter`=1, otherwise 0.
- `game_ready` in 1: core has finished the turn; position and status inputs are valid.
- `game_cowboypos` in 4: cowboy position from the core.
- `game_horsepos` in 4: horse position from the core.
- `game_gameover` in 1: game over flag from the core.
- `game_lostwon` in 1: 1 = won, 0 = lost; meaningful only when gameover=1.
- `data` out 4: serialised output nibble.
- `frame` out 1: high while `data` carries the first nibble of a burst.
- `gameover` out 1: registered game over status.
- `lostwon` out 1: registered lost/won status.
- `ready` out 1: high only in IDLE, when a new move is accepted.
- `timeout_err` out 1: sticky; set when WAIT expires.

## Operation
- All outputs are registered.
- Reset values:
  - `data`=0, `frame`=0, `ready`=0, `game_enter`=0, `game_move`=0.
  - `gameover`=1, `lostwon`=0, `timeout_err`=0.
  - State = IDLE, move counter = 0, edge register = 0.
- Edge detect: `enter_q` <= `enter` every cycle. A rise is `enter & ~enter_q`.
- States:
  - IDLE: `ready`=1, `data`=0. On a rise, latch `move` and go to ISSUE. Rises in any other state are dropped, not queued.
  - ISSUE (1 cycle): `game_enter`=1, `game_move`=latched move. Increment the move counter (4-bit, saturates at 15). If `clear_pending` is set, the counter loads 1 and `clear_pending` clears. Go to WAIT and load the timeout counter.
  - WAIT: on `game_ready`=1, capture both positions and both flags, then go to SHOW_COWBOY. If `TIMEOUT_CYCLES` cycles elapse without `game_ready`, set `timeout_err` and go to IDLE; `gameover`/`lostwon` stay unchanged. `game_ready` arriving in the expiry cycle wins over the timeout.
  - SHOW_COWBOY: `data`=captured cowboy position, `frame`=1.
  - SHOW_HORSE: `data`=captured horse position, `frame`=0.
  - SHOW_STATUS: `data`={2'b00, lostwon, gameover}. Update the `gameover`/`lostwon` outputs here. If gameover=1, set `clear_pending`.
  - SHOW_MOVES: present only with the macro; `data`=move counter.
  - After the last SHOW state, return to IDLE.
- Each SHOW state lasts exactly `HOLD_CYCLES` cycles, counted by an 8-bit dwell counter.
- `timeout_err` clears only on reset.

## Timing
- Rise sampled at edge N: `game_enter`=1 during cycle N+1 (ISSUE). WAIT begins at N+2.
- `game_ready` sampled at edge M: SHOW_COWBOY outputs are visible from M+1.
- Burst length = 3×`HOLD_CYCLES` cycles (4× with the macro). IDLE and `ready`=1 follow the cycle after the burst.
- Minimum turn with `HOLD_CYCLES`=1 and `game_ready` already high: rise to `ready` is 6 cycles (7 with the macro).
- `ready` first rises one cycle after `reset_n` deasserts.
- Asserting `reset_n` mid-burst or mid-WAIT forces reset values immediately. No partial frame resumes.

## Configuration
- `CORRAL_MOVE_COUNT_EN` defined: the move counter and SHOW_MOVES are compiled in; bursts carry four nibbles.
- Not defined: no counter logic, `clear_pending` is unused, and bursts carry three nibbles.

## Test plan
- Reset, then idle 3 cycles -> `ready`=1, `gameover`=1, `lostwon`=0, `data`=0, `timeout_err`=0.
- `move`=3'b101, `enter` rises; core returns ready 2 cycles later with cowboy=4'h3, horse=4'hA, gameover=0; `HOLD_CYCLES`=1 -> `game_enter` pulses once with `game_move`=5, then `data` reads 3 (frame=1), A, 0, then `ready`=1.
- Hold `enter` high across a full turn, and toggle it during WAIT -> exactly one `game_enter` pulse per rise accepted in IDLE.
- Core never asserts ready, `TIMEOUT_CYCLES`=4 -> `timeout_err`=1 four cycles after WAIT entry; back in IDLE; `gameover` unchanged.
- Core returns gameover=1, lostwon=1 -> status nibble 4'b0011, `gameover`=1, `lostwon`=1. With the macro, the next turn's count nibble is 1.
- Assert `reset_n` during SHOW_HORSE -> all outputs take reset values within the same cycle; the next turn behaves normally.
